// File: rtl/regfile_exec_pkg.sv
// rtl/regfile_exec_pkg.sv - shared state encoding, opcode constants and instruction field helpers
package regfile_exec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAUNCH,
    WAIT,
    WB
  } state_t;

  localparam logic [4:0] OP_MUL = 5'b01100;
  localparam logic [4:0] OP_DIV = 5'b01101;

  function automatic logic [31:0] instr_op(input logic [31:0] instr, input int unsigned op_w);
    return instr >> (32 - op_w);
  endfunction

  // idx 0 = dest, 1 = srcA, 2 = srcB; fields pack downward directly under the opcode
  function automatic logic [31:0] instr_reg(input logic [31:0] instr, input int unsigned op_w,
                                            input int unsigned aw, input int unsigned idx);
    return (instr >> (32 - op_w - (idx + 1) * aw)) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/gp_regfile.sv
// rtl/gp_regfile.sv - NREGS x DATA_W register file, two async read ports, debug read, one sync write
module gp_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int REG_AW = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic [REG_AW-1:0] i_ra_addr,
  output logic [DATA_W-1:0] o_ra_data,
  input  logic [REG_AW-1:0] i_rb_addr,
  output logic [DATA_W-1:0] o_rb_data,
  input  logic [REG_AW-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_regs [NREGS];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // r0 reads as zero regardless of array contents
  assign o_ra_data  = (i_ra_addr  == '0) ? '0 : r_regs[i_ra_addr];
  assign o_rb_data  = (i_rb_addr  == '0) ? '0 : r_regs[i_rb_addr];
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];

endmodule

// File: rtl/regfile_exec_seq.sv
// rtl/regfile_exec_seq.sv - sequenced regfile/ALU control path; REGFILE_EXEC_SEQ_HILO_EN adds HI/LO for MUL/DIV
module regfile_exec_seq #(
  parameter int DATA_W      = 32,
  parameter int NREGS       = 16,
  parameter int OP_W        = 5,
  parameter int ALU_TIMEOUT = 64,
  parameter int REG_AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [31:0]         instr,
  output logic [OP_W-1:0]     alu_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic                busy,
  output logic                err_timeout,
  input  logic [REG_AW-1:0]   dbg_sel,
  output logic [DATA_W-1:0]   dbg_data
`ifdef REGFILE_EXEC_SEQ_HILO_EN
  ,
  output logic [DATA_W-1:0]   hi_out,
  output logic [DATA_W-1:0]   lo_out
`endif
);

  import regfile_exec_pkg::*;

  localparam int CNT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;

  state_t            r_state, w_next;
  logic [OP_W-1:0]   r_op;
  logic [REG_AW-1:0] r_dest, r_srca, r_srcb;
  logic [DATA_W-1:0] r_a, r_b;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              w_accept, w_expire, w_hilo_op, w_we;
  logic [DATA_W-1:0] w_rd_a, w_rd_b;

`ifdef REGFILE_EXEC_SEQ_HILO_EN
  logic [2*DATA_W-1:0] r_result;
  logic [DATA_W-1:0]   r_hi, r_lo;
  assign w_hilo_op = (r_op == OP_W'(OP_MUL)) || (r_op == OP_W'(OP_DIV));
  assign hi_out    = r_hi;
  assign lo_out    = r_lo;
`else
  logic [DATA_W-1:0] r_result;
  assign w_hilo_op = 1'b0;

  function automatic logic [DATA_W-1:0] lo_half(input logic [2*DATA_W-1:0] v);
    return v[DATA_W-1:0];
  endfunction
`endif

  assign w_accept = (r_state == IDLE) && instr_valid;
  assign w_expire = (r_cnt == CNT_W'(ALU_TIMEOUT - 1));
  assign w_we     = (r_state == WB) && !w_hilo_op;

  always_ff @(posedge clk) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    alu_start   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) w_next = READ;
      end
      READ:   w_next = LAUNCH;
      LAUNCH: begin
        alu_start = 1'b1;
        w_next    = WAIT;
      end
      // a done coinciding with expiry still takes the writeback path
      WAIT: begin
        if (alu_done)      w_next = WB;
        else if (w_expire) w_next = IDLE;
      end
      WB:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_op     <= '0;
      r_dest   <= '0;
      r_srca   <= '0;
      r_srcb   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op   <= OP_W'(instr_op(instr, OP_W));
        r_dest <= REG_AW'(instr_reg(instr, OP_W, REG_AW, 0));
        r_srca <= REG_AW'(instr_reg(instr, OP_W, REG_AW, 1));
        r_srcb <= REG_AW'(instr_reg(instr, OP_W, REG_AW, 2));
      end
      if (r_state == READ) begin
        r_a <= w_rd_a;
        r_b <= w_rd_b;
      end
      if (r_state == LAUNCH) r_cnt <= '0;
      else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
      if (r_state == WAIT) begin
        if (alu_done) begin
`ifdef REGFILE_EXEC_SEQ_HILO_EN
          r_result <= alu_result;
`else
          r_result <= lo_half(alu_result);
`endif
        end else if (w_expire) begin
          r_err <= 1'b1;
        end
      end
    end
  end

`ifdef REGFILE_EXEC_SEQ_HILO_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if ((r_state == WB) && w_hilo_op) begin
      r_hi <= r_result[2*DATA_W-1:DATA_W];
      r_lo <= r_result[DATA_W-1:0];
    end
  end
`endif

  gp_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS),
    .REG_AW(REG_AW)
  ) u_regs (
    .i_clk     (clk),
    .i_clr     (clr),
    .i_ra_addr (r_srca),
    .o_ra_data (w_rd_a),
    .i_rb_addr (r_srcb),
    .o_rb_data (w_rd_b),
    .i_dbg_addr(dbg_sel),
    .o_dbg_data(dbg_data),
    .i_we      (w_we),
    .i_waddr   (r_dest),
    .i_wdata   (r_result[DATA_W-1:0])
  );

  assign alu_op      = r_op;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_regfile_exec_seq.sv
// tb/tb_regfile_exec_seq.sv - directed self-checking bench for regfile_exec_seq (ALU_TIMEOUT=8)
module tb_regfile_exec_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        alu_start;
  logic        alu_done;
  logic [63:0] alu_result;
  logic        busy;
  logic        err_timeout;
  logic [3:0]  dbg_sel;
  logic [31:0] dbg_data;
`ifdef REGFILE_EXEC_SEQ_HILO_EN
  logic [31:0] hi_out, lo_out;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_exec_seq #(
    .DATA_W(32), .NREGS(16), .OP_W(5), .ALU_TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .busy       (busy),
    .err_timeout(err_timeout),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
`ifdef REGFILE_EXEC_SEQ_HILO_EN
    ,
    .hi_out     (hi_out),
    .lo_out     (lo_out)
`endif
  );

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] d,
                                      input logic [3:0] a, input logic [3:0] b);
    return {op, d, a, b, 15'h0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] sel, output logic [31:0] v);
    dbg_sel = sel;
    #1;
    v = dbg_data;
  endtask

  // issue one instruction and answer it after dly WAIT cycles; returns operands seen at launch
  task automatic run_instr(input logic [4:0] op, input logic [3:0] d, input logic [3:0] a,
                           input logic [3:0] b, input logic [63:0] res, input int dly,
                           output logic [31:0] oa, output logic [31:0] ob);
    int n;
    instr = enc(op, d, a, b);
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin step(); n++; end
    step();
    instr_valid = 1'b0;
    n = 0;
    while (!alu_start && n < 10) begin step(); n++; end
    total++;
    if (alu_start !== 1'b1) begin
      bad++;
      $display("FAIL run_start got=%b want=1", alu_start);
    end
    oa = alu_a;
    ob = alu_b;
    step();
    repeat (dly) step();
    alu_done = 1'b1;
    alu_result = res;
    step();
    alu_done = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    clr = 1'b1;
    step();
    step();
    clr = 1'b0;
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", instr_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (alu_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%b want=0", alu_start); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err_timeout); end
    total++; if ({alu_op, alu_a, alu_b} !== 69'h0) begin bad++; $display("FAIL rst_alu got=%h want=0", {alu_op, alu_a, alu_b}); end
`ifdef REGFILE_EXEC_SEQ_HILO_EN
    total++; if ({hi_out, lo_out} !== 64'h0) begin bad++; $display("FAIL rst_hilo got=%h want=0", {hi_out, lo_out}); end
`endif
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL rst_dbg%0d got=%h want=0", i, v); end
    end
  endtask

  task automatic test_r0_write();
    logic [31:0] oa, ob, v;
    run_instr(5'h1, 4'd0, 4'd0, 4'd0, 64'h1234, 0, oa, ob);
    rd(4'd0, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL r0_write got=%h want=0", v); end
  endtask

  task automatic test_preload_add();
    logic [31:0] oa, ob, v;
    run_instr(5'h2, 4'd3, 4'd0, 4'd0, 64'h5, 0, oa, ob);
    rd(4'd3, v);
    total++; if (v !== 32'h5) begin bad++; $display("FAIL preload_r3 got=%h want=5", v); end
    instr = enc(5'h1, 4'd4, 4'd3, 4'd3);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    total++; if (alu_start !== 1'b1) begin bad++; $display("FAIL add_start got=%b want=1", alu_start); end
    total++; if (alu_op !== 5'h1) begin bad++; $display("FAIL add_op got=%h want=1", alu_op); end
    total++; if (alu_a !== 32'h5) begin bad++; $display("FAIL add_a got=%h want=5", alu_a); end
    total++; if (alu_b !== 32'h5) begin bad++; $display("FAIL add_b got=%h want=5", alu_b); end
    step();
    alu_done = 1'b1;
    alu_result = 64'hA;
    step();
    alu_done = 1'b0;
    rd(4'd4, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL add_early got=%h want=0", v); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_wb_busy got=%b want=1", busy); end
    step();
    rd(4'd4, v);
    total++; if (v !== 32'hA) begin bad++; $display("FAIL add_r4 got=%h want=a", v); end
    total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%b want=1", instr_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa, ob, v;
    alu_done = 1'b1;
    alu_result = 64'hDEAD;
    step();
    alu_done = 1'b0;
    rd(4'd4, v);
    total++; if (v !== 32'hA) begin bad++; $display("FAIL idle_done got=%h want=a", v); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_done_busy got=%b want=0", busy); end
    run_instr(5'h1, 4'd4, 4'd4, 4'd3, 64'hF, 0, oa, ob);
    total++; if (oa !== 32'hA) begin bad++; $display("FAIL b2b_a got=%h want=a", oa); end
    total++; if (ob !== 32'h5) begin bad++; $display("FAIL b2b_b got=%h want=5", ob); end
    rd(4'd4, v);
    total++; if (v !== 32'hF) begin bad++; $display("FAIL b2b_r4 got=%h want=f", v); end
    run_instr(5'h3, 4'd8, 4'd4, 4'd4, 64'hFFFF_0000_0000_0021, 2, oa, ob);
    rd(4'd8, v);
    total++; if (v !== 32'h21) begin bad++; $display("FAIL slow_r8 got=%h want=21", v); end
  endtask

  task automatic test_timeout();
    logic [31:0] oa, ob, v;
    int n;
    instr = enc(5'h3, 4'd5, 4'd3, 4'd4);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    n = 0;
    while (!alu_start && n < 10) begin step(); n++; end
    step();
    repeat (7) step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL to_busy7 got=%b want=1", busy); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", err_timeout); end
    step();
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", err_timeout); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%b want=0", busy); end
    rd(4'd5, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL to_r5 got=%h want=0", v); end
    run_instr(5'h3, 4'd5, 4'd3, 4'd4, 64'h77, 0, oa, ob);
    rd(4'd5, v);
    total++; if (v !== 32'h77) begin bad++; $display("FAIL to_next got=%h want=77", v); end
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", err_timeout); end
  endtask

  task automatic test_clr_mid_wait();
    logic [31:0] v;
    int n;
    instr = enc(5'h1, 4'd6, 4'd4, 4'd5);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    n = 0;
    while (!alu_start && n < 10) begin step(); n++; end
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b want=0", busy); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL clr_err got=%b want=0", err_timeout); end
    total++; if (alu_a !== 32'h0) begin bad++; $display("FAIL clr_alu_a got=%h want=0", alu_a); end
    alu_done = 1'b1;
    alu_result = 64'h99;
    step();
    step();
    alu_done = 1'b0;
    for (int i = 3; i <= 8; i++) begin
      rd(4'(i), v);
      total++;
      if (v !== 32'h0) begin bad++; $display("FAIL clr_r%0d got=%h want=0", i, v); end
    end
  endtask

  task automatic test_hilo();
    logic [31:0] oa, ob, v;
    run_instr(5'h2, 4'd1, 4'd0, 4'd0, 64'hFFFF_FFFF, 0, oa, ob);
    run_instr(5'h2, 4'd2, 4'd0, 4'd0, 64'h2, 0, oa, ob);
    run_instr(5'b01100, 4'd7, 4'd1, 4'd2, 64'h1_FFFF_FFFE, 0, oa, ob);
    total++; if (oa !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mul_a got=%h want=ffffffff", oa); end
    total++; if (ob !== 32'h2) begin bad++; $display("FAIL mul_b got=%h want=2", ob); end
    rd(4'd7, v);
`ifdef REGFILE_EXEC_SEQ_HILO_EN
    total++; if (hi_out !== 32'h1) begin bad++; $display("FAIL mul_hi got=%h want=1", hi_out); end
    total++; if (lo_out !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mul_lo got=%h want=fffffffe", lo_out); end
    total++; if (v !== 32'h0) begin bad++; $display("FAIL mul_r7 got=%h want=0", v); end
`else
    total++; if (v !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mul_r7 got=%h want=fffffffe", v); end
`endif
  endtask

  initial begin
    clr = 1'b1;
    instr_valid = 1'b0;
    instr = 32'h0;
    alu_done = 1'b0;
    alu_result = 64'h0;
    dbg_sel = 4'd0;
    #1;
    test_reset();
    test_r0_write();
    test_preload_add();
    test_back_to_back();
    test_timeout();
    test_clr_mid_wait();
    test_hilo();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
